// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the GPIO parallel-bus register bank.
// Provides default bus geometry and the slice offset helper for flattened buses.
package gpio_pkg;

    localparam int GPIO_DATA_W   = 10;
    localparam int GPIO_ADDR_W   = 3;
    localparam int GPIO_FILT_LEN = 2;

    // Bit offset of slice idx in a bus made of equal width-bit slices.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/gpio_strobe_filter.sv
// Two-flop synchroniser plus glitch filter for one asynchronous host strobe.
// The level is accepted after FILT_LEN consecutive synchronised-high cycles.
module gpio_strobe_filter
    import gpio_pkg::*;
#(
    parameter int FILT_LEN = GPIO_FILT_LEN
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic strobe_i,
    output logic level_o,
    output logic rise_o
);

    localparam int            CW      = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_prev_q;

    // cnt_q holds the high cycles seen before the current one, so the current
    // synchronised-high cycle completes the run when cnt_q reaches FILT_LEN-1.
    always_comb begin
        cnt_d = '0;
        if (!sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign level_o = sync2_q && (cnt_q == CNT_MAX);
    assign rise_o  = level_o && !level_prev_q;

    // Synchroniser, run counter and edge-detect history.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_prev_q <= 1'b0;
        end else begin
            sync1_q      <= strobe_i;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_prev_q <= level_o;
        end
    end

endmodule

// File: rtl/gpio_regbank.sv
// Register bank behind the asynchronous Raspberry Pi GPIO parallel bus:
// filtered write/read strobes, per-register write pulses and host read-back.
module gpio_regbank
    import gpio_pkg::*;
#(
    parameter int                       DATA_W   = GPIO_DATA_W,
    parameter int                       ADDR_W   = GPIO_ADDR_W,
    parameter int                       FILT_LEN = GPIO_FILT_LEN,
    parameter logic [(2**ADDR_W)-1:0]   RO_MASK  = '0,
    parameter logic [DATA_W-1:0]        RST_VAL  = '0
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              HOST_WR,
    input  logic                              HOST_RD,
    input  logic [ADDR_W-1:0]                 HOST_ADDR,
    input  logic [DATA_W-1:0]                 HOST_DIN,
    output logic [DATA_W-1:0]                 HOST_DOUT,
    output logic                              HOST_DOE,
    input  logic [(2**ADDR_W)*DATA_W-1:0]     STATUS_IN,
    output logic [(2**ADDR_W)*DATA_W-1:0]     REG_Q,
    output logic [(2**ADDR_W)-1:0]            WR_PULSE,
    output logic                              ERR
);

    localparam int NREG = 2**ADDR_W;

    logic                     wr_level;
    logic                     wr_rise;
    logic                     rd_level;
    logic                     rd_rise;
    logic                     unused_s;

    logic [ADDR_W-1:0]        addr_s1_q;
    logic [ADDR_W-1:0]        addr_s2_q;
    logic [DATA_W-1:0]        din_s1_q;
    logic [DATA_W-1:0]        din_s2_q;

    logic [NREG*DATA_W-1:0]   reg_q;
    logic [NREG*DATA_W-1:0]   reg_d;
    logic [NREG-1:0]          pulse_q;
    logic [NREG-1:0]          pulse_d;
    logic                     err_q;
    logic                     err_d;
    logic                     doe_q;
    logic                     doe_d;
    logic [DATA_W-1:0]        dout_q;
    logic [DATA_W-1:0]        dout_d;
    logic [31:0]              sel_lo;
    logic                     sel_ro;

    gpio_strobe_filter #(.FILT_LEN(FILT_LEN)) u_wr_filt (
        .clk_i    (CLK),
        .rst_i    (RST),
        .strobe_i (HOST_WR),
        .level_o  (wr_level),
        .rise_o   (wr_rise)
    );

    gpio_strobe_filter #(.FILT_LEN(FILT_LEN)) u_rd_filt (
        .clk_i    (CLK),
        .rst_i    (RST),
        .strobe_i (HOST_RD),
        .level_o  (rd_level),
        .rise_o   (rd_rise)
    );

    assign unused_s = &{1'b0, wr_level, rd_rise};

    // Address and data rely on the host holding them stable around the strobe,
    // so a plain two-flop vector synchroniser is enough.
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_s1_q <= '0;
            addr_s2_q <= '0;
            din_s1_q  <= '0;
            din_s2_q  <= '0;
        end else begin
            addr_s1_q <= HOST_ADDR;
            addr_s2_q <= addr_s1_q;
            din_s1_q  <= HOST_DIN;
            din_s2_q  <= din_s1_q;
        end
    end

    // A write landing on a read-only slot or overlapping a read is dropped and flagged.
    always_comb begin
        reg_d   = reg_q;
        pulse_d = '0;
        err_d   = err_q;
        doe_d   = rd_level;
        dout_d  = dout_q;
        sel_lo  = slice_lo(32'(addr_s2_q), 32'(DATA_W));
        sel_ro  = RO_MASK[addr_s2_q];
        if (wr_rise && (rd_level || sel_ro)) begin
            err_d = 1'b1;
        end else if (wr_rise) begin
            reg_d[sel_lo +: DATA_W] = din_s2_q;
            pulse_d[addr_s2_q]      = 1'b1;
        end else begin
            err_d = err_q;
        end
        if (rd_level) begin
            dout_d = sel_ro ? STATUS_IN[sel_lo +: DATA_W] : reg_q[sel_lo +: DATA_W];
        end else begin
            dout_d = dout_q;
        end
    end

    // Register file and registered host-side outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                reg_q[i*DATA_W +: DATA_W] <= RO_MASK[i] ? '0 : RST_VAL;
            end
            pulse_q <= '0;
            err_q   <= 1'b0;
            doe_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            reg_q   <= reg_d;
            pulse_q <= pulse_d;
            err_q   <= err_d;
            doe_q   <= doe_d;
            dout_q  <= dout_d;
        end
    end

    assign REG_Q     = reg_q;
    assign WR_PULSE  = pulse_q;
    assign ERR       = err_q;
    assign HOST_DOE  = doe_q;
    assign HOST_DOUT = dout_q;

endmodule

// File: tb/tb_gpio_regbank.sv
// Directed plus randomized bench for gpio_regbank against a host-transaction-level model.
module tb_gpio_regbank;

    localparam int         DW = 10;
    localparam int         NR = 8;
    localparam int         FL = 2;
    localparam logic [7:0] RO = 8'h80;

    logic        CLK = 1'b0;
    logic        RST;
    logic        HOST_WR;
    logic        HOST_RD;
    logic [2:0]  HOST_ADDR;
    logic [9:0]  HOST_DIN;
    logic [9:0]  HOST_DOUT;
    logic        HOST_DOE;
    logic [79:0] STATUS_IN;
    logic [79:0] REG_Q;
    logic [7:0]  WR_PULSE;
    logic        ERR;

    int total = 0;
    int bad   = 0;

    // Reference model: register contents, sticky error, last read-back value.
    logic [9:0] m_reg [NR];
    logic       m_err;
    logic [9:0] m_dout;

    gpio_regbank #(.RO_MASK(RO)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .HOST_WR   (HOST_WR),
        .HOST_RD   (HOST_RD),
        .HOST_ADDR (HOST_ADDR),
        .HOST_DIN  (HOST_DIN),
        .HOST_DOUT (HOST_DOUT),
        .HOST_DOE  (HOST_DOE),
        .STATUS_IN (STATUS_IN),
        .REG_Q     (REG_Q),
        .WR_PULSE  (WR_PULSE),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] exp_regs();
        logic [79:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) begin
            r[i*DW +: DW] = RO[i] ? 10'h000 : m_reg[i];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_reg[i] = 10'h000;
        m_err  = 1'b0;
        m_dout = 10'h000;
    endtask

    // One host write: strobe held for 'hold' clock periods, then released.
    task automatic host_write(input logic [2:0] a, input logic [9:0] d, input int hold, input bit rd_on);
        int         npulse;
        int         at;
        logic [7:0] pv;
        bit         acc;
        @(negedge CLK);
        HOST_ADDR = a;
        HOST_DIN  = d;
        repeat (3) @(negedge CLK);
        HOST_WR = 1'b1;
        npulse  = 0;
        at      = 0;
        pv      = 8'h00;
        for (int c = 1; c <= hold + 8; c++) begin
            @(negedge CLK);
            if (c == hold) HOST_WR = 1'b0;
            if (WR_PULSE != 8'h00) begin
                npulse++;
                at = c;
                pv = WR_PULSE;
            end
        end
        acc = (hold >= FL) && !rd_on && !RO[a];
        if ((hold >= FL) && (rd_on || RO[a])) m_err = 1'b1;
        if (acc) m_reg[a] = d;
        chk("wr_npulse", 80'(npulse), 80'(acc ? 1 : 0));
        chk("wr_pulse_at", 80'(at), 80'(acc ? FL + 2 : 0));
        chk("wr_pulse_val", 80'(pv), 80'(acc ? (8'h01 << a) : 8'h00));
        chk("wr_reg_q", REG_Q, exp_regs());
        chk("wr_err", 80'(ERR), 80'(m_err));
    endtask

    // One host read: checks DOE latency, read-back data, and release behaviour.
    task automatic host_read(input logic [2:0] a);
        logic [9:0] e;
        @(negedge CLK);
        HOST_ADDR = a;
        repeat (3) @(negedge CLK);
        HOST_RD = 1'b1;
        repeat (FL + 1) @(negedge CLK);
        chk("rd_doe_early", 80'(HOST_DOE), 80'(0));
        @(negedge CLK);
        e      = RO[a] ? STATUS_IN[a*DW +: DW] : m_reg[a];
        m_dout = e;
        chk("rd_doe", 80'(HOST_DOE), 80'(1));
        chk("rd_dout", 80'(HOST_DOUT), 80'(e));
        HOST_RD = 1'b0;
        repeat (4) @(negedge CLK);
        chk("rd_doe_off", 80'(HOST_DOE), 80'(0));
        chk("rd_dout_hold", 80'(HOST_DOUT), 80'(m_dout));
    endtask

    initial begin
        int         npulse;
        logic [2:0] ra;
        logic [9:0] rdat;
        int         rhold;

        RST       = 1'b1;
        HOST_WR   = 1'b0;
        HOST_RD   = 1'b0;
        HOST_ADDR = 3'd0;
        HOST_DIN  = 10'h000;
        for (int i = 0; i < NR; i++) STATUS_IN[i*DW +: DW] = 10'($urandom);
        STATUS_IN[7*DW +: DW] = 10'h2C3;
        model_reset();
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        chk("rst_reg_q", REG_Q, exp_regs());
        chk("rst_pulse", 80'(WR_PULSE), 80'(0));
        chk("rst_doe", 80'(HOST_DOE), 80'(0));
        chk("rst_dout", 80'(HOST_DOUT), 80'(0));
        chk("rst_err", 80'(ERR), 80'(0));

        host_write(3'd2, 10'h155, 3, 1'b0);
        host_write(3'd1, 10'h3FF, 1, 1'b0);
        host_write(3'd0, 10'h0AA, 50, 1'b0);
        host_read(3'd2);
        host_read(3'd7);
        host_write(3'd7, 10'h001, 3, 1'b0);

        // Reset lands while a write is in flight.
        @(negedge CLK);
        HOST_ADDR = 3'd3;
        HOST_DIN  = 10'h2AA;
        repeat (3) @(negedge CLK);
        HOST_WR = 1'b1;
        repeat (2) @(negedge CLK);
        RST     = 1'b1;
        HOST_WR = 1'b0;
        model_reset();
        npulse = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (c == 1) RST = 1'b0;
            if (WR_PULSE != 8'h00) npulse++;
        end
        chk("midrst_npulse", 80'(npulse), 80'(0));
        chk("midrst_reg_q", REG_Q, exp_regs());
        chk("midrst_err", 80'(ERR), 80'(0));
        chk("midrst_doe", 80'(HOST_DOE), 80'(0));
        chk("midrst_dout", 80'(HOST_DOUT), 80'(0));

        // Write collides with an active read of the same register.
        host_write(3'd2, 10'h155, 2, 1'b0);
        HOST_RD = 1'b1;
        repeat (5) @(negedge CLK);
        host_write(3'd2, 10'h0F0, 3, 1'b1);
        chk("coll_doe", 80'(HOST_DOE), 80'(1));
        chk("coll_dout", 80'(HOST_DOUT), 80'(10'h155));
        HOST_RD = 1'b0;
        m_dout  = 10'h155;
        repeat (4) @(negedge CLK);
        chk("coll_doe_off", 80'(HOST_DOE), 80'(0));

        model_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst2_err", 80'(ERR), 80'(0));

        for (int n = 0; n < 30; n++) begin
            ra    = 3'($urandom_range(0, 7));
            rdat  = 10'($urandom);
            rhold = int'($urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) host_read(ra);
            else host_write(ra, rdat, rhold, 1'b0);
        end
        for (int i = 0; i < NR; i++) host_read(3'(i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
